tpu_apb_sequencer: RTL

APB master that programs and runs one TPU operation with no host in the loop. On a start pulse it issues a fixed-length list of configuration register writes over the TPU's APB slave port, writes the start command, and polls the status register until the done bit sets or a poll budget is spent. It then clears the start register and reports completion. It sits between the test wrapper (random BRAM stimulus, byte-select readout) and the TPU `top` instance's PADDR/PWRITE/PSEL/PENABLE/PWDATA/PRDATA/PREADY pins.

---
 rtl/tpu_apb_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_apb_sequencer.sv
// APB master that runs one TPU operation: configuration writes, a start write,
// status polling with an idle gap between reads, then a clear write.
module tpu_apb_sequencer #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int NUM_CFG = 8,
  parameter logic [REG_ADDRWIDTH-1:0] START_ADDR = 8'h00,
  parameter logic [REG_ADDRWIDTH-1:0] STATUS_ADDR = 8'h00,
  parameter int DONE_BIT = 31,
  parameter int POLL_GAP = 4,
  parameter int MAX_POLLS = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_CFG*REG_ADDRWIDTH-1:0] cfg_addr,
  input  logic [NUM_CFG*REG_DATAWIDTH-1:0] cfg_data,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_err,
  output logic [15:0]                      poll_count,
  output logic [REG_ADDRWIDTH-1:0]         PADDR,
  output logic                             PWRITE,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic [REG_DATAWIDTH-1:0]         PWDATA,
  input  logic [REG_DATAWIDTH-1:0]         PRDATA,
  input  logic                             PREADY
);
  localparam int AW = REG_ADDRWIDTH;
  localparam int DW = REG_DATAWIDTH;
  localparam int IW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CFG - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    GO    = 3'd2,
    POLL  = 3'd3,
    GAP   = 3'd4,
    CLEAR = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t                     state_r, state_s;
  logic [IW-1:0]              idx_r, idx_s, idx_nx_s;
  logic [GW-1:0]              gap_r, gap_s;
  logic [NUM_CFG*AW-1:0]      cap_addr_r, cap_addr_s;
  logic [NUM_CFG*DW-1:0]      cap_data_r, cap_data_s;
  logic                       busy_r, busy_s, done_r, done_s, timeout_r, timeout_s;
  logic [15:0]                poll_r, poll_s, poll_inc_s;
  logic                       psel_r, psel_s, penable_r, penable_s, pwrite_r, pwrite_s;
  logic [AW-1:0]              paddr_r, paddr_s;
  logic [DW-1:0]              pwdata_r, pwdata_s;
  logic                       setup_s, access_done_s;

  assign setup_s       = psel_r & ~penable_r;
  assign access_done_s = psel_r & penable_r & PREADY;
  assign poll_inc_s    = (poll_r == 16'hFFFF) ? poll_r : poll_r + 16'd1;
  assign idx_nx_s      = (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);

  // Next-state and next-output computation; every bus phase change is decided here.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    gap_s      = gap_r;
    cap_addr_s = cap_addr_r;
    cap_data_s = cap_data_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    timeout_s  = timeout_r;
    poll_s     = poll_r;
    psel_s     = psel_r;
    penable_s  = penable_r;
    pwrite_s   = pwrite_r;
    paddr_s    = paddr_r;
    pwdata_s   = pwdata_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = CFG;
          cap_addr_s = cfg_addr;
          cap_data_s = cfg_data;
          idx_s      = '0;
          timeout_s  = 1'b0;
          poll_s     = 16'd0;
          busy_s     = 1'b1;
          psel_s     = 1'b1;
          penable_s  = 1'b0;
          pwrite_s   = 1'b1;
          paddr_s    = cfg_addr[0 +: AW];
          pwdata_s   = cfg_data[0 +: DW];
        end else begin
          state_s = IDLE;
        end
      end
      CFG: begin
        if (setup_s) begin
          penable_s = 1'b1;
        end else if (access_done_s) begin
          penable_s = 1'b0;
          if (idx_r == IDX_LAST) begin
            state_s  = GO;
            paddr_s  = START_ADDR;
            pwdata_s = DW'(1);
          end else begin
            idx_s    = idx_nx_s;
            paddr_s  = cap_addr_r[idx_nx_s*AW +: AW];
            pwdata_s = cap_data_r[idx_nx_s*DW +: DW];
          end
        end else begin
          penable_s = penable_r;
        end
      end
      GO: begin
        if (setup_s) begin
          penable_s = 1'b1;
        end else if (access_done_s) begin
          state_s   = POLL;
          penable_s = 1'b0;
          pwrite_s  = 1'b0;
          paddr_s   = STATUS_ADDR;
        end else begin
          penable_s = penable_r;
        end
      end
      POLL: begin
        if (setup_s) begin
          penable_s = 1'b1;
        end else if (access_done_s) begin
          poll_s    = poll_inc_s;
          penable_s = 1'b0;
          // A done bit on the last allowed read wins over the timeout.
          if (PRDATA[DONE_BIT] || (int'({16'd0, poll_inc_s}) >= MAX_POLLS)) begin
            state_s   = CLEAR;
            timeout_s = ~PRDATA[DONE_BIT];
            pwrite_s  = 1'b1;
            paddr_s   = START_ADDR;
            pwdata_s  = DW'(0);
          end else if (POLL_GAP == 0) begin
            state_s = POLL;
          end else begin
            state_s = GAP;
            psel_s  = 1'b0;
            gap_s   = '0;
          end
        end else begin
          penable_s = penable_r;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s   = POLL;
          psel_s    = 1'b1;
          penable_s = 1'b0;
        end else begin
          gap_s = gap_r + GW'(1);
        end
      end
      CLEAR: begin
        if (setup_s) begin
          penable_s = 1'b1;
        end else if (access_done_s) begin
          state_s   = FIN;
          psel_s    = 1'b0;
          penable_s = 1'b0;
          pwrite_s  = 1'b0;
          done_s    = 1'b1;
          busy_s    = 1'b0;
        end else begin
          penable_s = penable_r;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        busy_s    = 1'b0;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        pwrite_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      gap_r      <= '0;
      cap_addr_r <= '0;
      cap_data_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      poll_r     <= 16'd0;
      psel_r     <= 1'b0;
      penable_r  <= 1'b0;
      pwrite_r   <= 1'b0;
      paddr_r    <= '0;
      pwdata_r   <= '0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      gap_r      <= gap_s;
      cap_addr_r <= cap_addr_s;
      cap_data_r <= cap_data_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      timeout_r  <= timeout_s;
      poll_r     <= poll_s;
      psel_r     <= psel_s;
      penable_r  <= penable_s;
      pwrite_r   <= pwrite_s;
      paddr_r    <= paddr_s;
      pwdata_r   <= pwdata_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout_err = timeout_r;
  assign poll_count  = poll_r;
  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PWDATA      = pwdata_r;
endmodule
